// File: rtl/neuron_a_bwd_pkg.sv
// neuron_a_bwd_pkg: Q8.24 constants and FSM state encoding for the backward neuron.
package neuron_a_bwd_pkg;
    localparam int W_DEF  = 32;
    localparam int FB_DEF = 24;
    localparam logic [31:0] Q_ONE = 32'(1) << FB_DEF;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;
    typedef enum logic [3:0] {
        IDLE, SQ, DELTA, LRD, P1, P2, P3, U1, U2, U3, DONE
    } state_e;
endpackage

// File: rtl/neuron_a_bwd_if.sv
// neuron_a_bwd_if: control, operand and result bundle between the trainer and the backward neuron.
interface neuron_a_bwd_if #(parameter int WIDTH = 32);
    logic             en, load, start, busy, done;
    logic [WIDTH-1:0] w_init_1, w_init_2, w_init_3, b_init;
    logic [WIDTH-1:0] a_1, a_2, a_3, y, err, lr;
    logic [WIDTH-1:0] w_1, w_2, w_3, b, e_1, e_2, e_3;
    modport slave (
        input  en, load, start, w_init_1, w_init_2, w_init_3, b_init,
               a_1, a_2, a_3, y, err, lr,
        output w_1, w_2, w_3, b, e_1, e_2, e_3, busy, done
    );
    modport master (
        output en, load, start, w_init_1, w_init_2, w_init_3, b_init,
               a_1, a_2, a_3, y, err, lr,
        input  w_1, w_2, w_3, b, e_1, e_2, e_3, busy, done
    );
endinterface

// File: rtl/neuron_a_bwd_mult_q.sv
// mult_Q: signed fixed-point multiply, full product shifted right by FBITS and truncated.
module mult_Q #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic        [WIDTH-1:0] p_o
);
    logic signed [2*WIDTH-1:0] full;
    assign full = a_i * b_i;
    assign p_o  = WIDTH'(full >>> FBITS);
endmodule

// File: rtl/neuron_a_bwd.sv
// neuron_a_bwd: tanh-neuron backward pass and SGD update on one shared Q8.24 multiplier.
module neuron_a_bwd
    import neuron_a_bwd_pkg::*;
#(
    parameter int WIDTH = W_DEF,
    parameter int FBITS = FB_DEF
) (
    input logic           clk,
    input logic           rst,
    neuron_a_bwd_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(Q_ONE);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(Q_MAX);
    localparam logic [WIDTH-1:0] MINV = WIDTH'(Q_MIN);

    state_e                  st_q, st_d;
    logic [WIDTH-1:0]        y_q, err_q, lr_q, p_q, dl_q, ld_q, b_q;
    logic [2:0][WIDTH-1:0]   a_q, w_q, e_q;
    logic                    busy_q, done_q;
    logic [WIDTH-1:0]        op_a, op_b, m;
    logic [1:0]              k;

    // Overflow only when operand signs differ and the result sign flips away from x.
    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] u);
        logic [WIDTH-1:0] d;
        d = x - u;
        return (x[WIDTH-1] != u[WIDTH-1] && d[WIDTH-1] != x[WIDTH-1]) ? (x[WIDTH-1] ? MINV : MAXV) : d;
    endfunction

    mult_Q #(.WIDTH(WIDTH), .FBITS(FBITS)) u_mult (.a_i(op_a), .b_i(op_b), .p_o(m));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st_q <= IDLE;
        else if (bus.en) st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    st_d = (bus.start && !bus.load) ? SQ : IDLE;
            DONE:    st_d = IDLE;
            default: st_d = state_e'(st_q + 4'd1);
        endcase
    end

    always_comb begin
        k    = 2'd0;
        op_a = '0;
        op_b = '0;
        case (st_q)
            SQ:         begin op_a = y_q;   op_b = y_q;       end
            DELTA:      begin op_a = err_q; op_b = ONE - p_q; end
            LRD:        begin op_a = lr_q;  op_b = dl_q;      end
            P1, P2, P3: begin k = 2'(st_q - P1); op_a = dl_q; op_b = w_q[k]; end
            U1, U2, U3: begin k = 2'(st_q - U1); op_a = ld_q; op_b = a_q[k]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {y_q, err_q, lr_q, p_q, dl_q, ld_q, b_q} <= '0;
            a_q    <= '0;
            w_q    <= '0;
            e_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.en) begin
            busy_q <= st_d != IDLE;
            done_q <= st_d == DONE;
            case (st_q)
                IDLE: begin
                    if (bus.load) begin
                        w_q <= {bus.w_init_3, bus.w_init_2, bus.w_init_1};
                        b_q <= bus.b_init;
                    end else if (bus.start) begin
                        a_q   <= {bus.a_3, bus.a_2, bus.a_1};
                        y_q   <= bus.y;
                        err_q <= bus.err;
                        lr_q  <= bus.lr;
                    end
                end
                SQ:         p_q    <= m;
                DELTA:      dl_q   <= m;
                LRD:        ld_q   <= m;
                P1, P2, P3: e_q[k] <= m;
                U1, U2, U3: begin
                    w_q[k] <= sat_sub(w_q[k], m);
                    if (st_q == U1) b_q <= sat_sub(b_q, ld_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.w_1  = w_q[0];
    assign bus.w_2  = w_q[1];
    assign bus.w_3  = w_q[2];
    assign bus.b    = b_q;
    assign bus.e_1  = e_q[0];
    assign bus.e_2  = e_q[1];
    assign bus.e_3  = e_q[2];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
